// File: rtl/blob_centroid_pkg.sv
// Shared definitions for the ball centroid tracker: colour codes, hue windows,
// FSM state encodings and the per-pixel colour classifier.
package blob_centroid_pkg;

    typedef enum logic [1:0] {
        COL_RED    = 2'd0,
        COL_BLUE   = 2'd1,
        COL_YELLOW = 2'd2,
        COL_NONE   = 2'd3
    } colour_e;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_DIV_X   = 2'd1,
        ST_DIV_Y   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_e;

    // Red wraps around 0 degrees, so it is the union of two open intervals.
    localparam logic [8:0] RED_ABOVE    = 9'd330;
    localparam logic [8:0] RED_BELOW    = 9'd20;
    localparam logic [8:0] BLUE_ABOVE   = 9'd160;
    localparam logic [8:0] BLUE_BELOW   = 9'd250;
    localparam logic [8:0] YELLOW_ABOVE = 9'd50;
    localparam logic [8:0] YELLOW_BELOW = 9'd70;

    function automatic logic hue_in_class(input logic [1:0] sel, input logic [8:0] hue);
        logic hit;
        hit = 1'b0;
        case (sel)
            COL_RED:    hit = (hue > RED_ABOVE) || (hue < RED_BELOW);
            COL_BLUE:   hit = (hue > BLUE_ABOVE) && (hue < BLUE_BELOW);
            COL_YELLOW: hit = (hue > YELLOW_ABOVE) && (hue < YELLOW_BELOW);
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/blob_centroid_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// produced on the start edge so a divide occupies exactly SUMW cycles.
module blob_centroid_serial_divider
    import blob_centroid_pkg::*;
#(
    parameter int SUMW = 28,
    parameter int CNTW = 19,
    parameter int QW   = 10
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            start_i,
    input  logic [SUMW-1:0] dividend_i,
    input  logic [CNTW-1:0] divisor_i,
    output logic            done_o,
    output logic [QW-1:0]   quotient_o
);

    localparam int CW = $clog2(SUMW + 1);

    logic [SUMW-1:0] dvd_q, dvd_d, src_dvd_s;
    logic [CNTW-1:0] rem_q, rem_d, src_rem_s;
    logic [CNTW-1:0] dvs_q, src_dvs_s;
    logic [CNTW:0]   trial_s;
    logic            ge_s;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;

    // One restoring step; on start it operates on the fresh operands.
    always_comb begin
        if (start_i) begin
            src_dvd_s = dividend_i;
            src_rem_s = {CNTW{1'b0}};
            src_dvs_s = divisor_i;
        end else begin
            src_dvd_s = dvd_q;
            src_rem_s = rem_q;
            src_dvs_s = dvs_q;
        end
        trial_s = {src_rem_s, src_dvd_s[SUMW-1]};
        ge_s    = (trial_s >= {1'b0, src_dvs_s});
        if (ge_s) begin
            rem_d = CNTW'(trial_s - {1'b0, src_dvs_s});
        end else begin
            rem_d = trial_s[CNTW-1:0];
        end
        dvd_d = {src_dvd_s[SUMW-2:0], ge_s};
    end

    // Iteration counter, operand registers and done pulse.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            dvd_q  <= {SUMW{1'b0}};
            rem_q  <= {CNTW{1'b0}};
            dvs_q  <= {CNTW{1'b0}};
            cnt_q  <= {CW{1'b0}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            dvs_q  <= divisor_i;
            cnt_q  <= CW'(SUMW - 1);
            busy_q <= (SUMW > 1);
            done_q <= (SUMW == 1);
        end else if (busy_q) begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q - CW'(1);
            busy_q <= (cnt_q != CW'(1));
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = dvd_q[QW-1:0];

endmodule

// File: rtl/blob_centroid.sv
// Classifies the HSV pixel stream against one ball colour, accumulates hit
// coordinates per frame and publishes the centroid after a serial divide.
module blob_centroid
    import blob_centroid_pkg::*;
#(
    parameter int          XW         = 10,
    parameter int          YW         = 10,
    parameter int          CNTW       = 19,
    parameter int          SUMW       = 28,
    parameter logic [4:0]  SAT_MIN    = 5'hC,
    parameter logic [4:0]  VAL_MIN    = 5'hC,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            vsync,
    input  logic            href,
    input  logic            done,
    input  logic [8:0]      hue,
    input  logic [4:0]      saturation,
    input  logic [4:0]      value,
    input  logic            hue_invalid,
    input  logic [1:0]      colour_sel,
    output logic [XW-1:0]   cx,
    output logic [YW-1:0]   cy,
    output logic [CNTW-1:0] pix_count,
    output logic            found,
    output logic            result_valid,
    output logic            busy
);

    localparam int QW = (XW > YW) ? XW : YW;

    logic            vsync_q, href_q;
    logic            frame_end_s, href_rise_s, href_fall_s, match_s, go_s;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [SUMW-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d, op_y_q;
    logic [CNTW-1:0] count_q, count_d, op_cnt_q;
    logic            ovf_q, ovf_d;
    logic [SUMW:0]   add_x_s, add_y_s;
    logic [CNTW:0]   add_c_s;
    state_e          state_q;
    logic [XW-1:0]   qx_q, cx_q;
    logic [YW-1:0]   cy_q;
    logic [CNTW-1:0] pix_count_q;
    logic            found_q, result_valid_q, busy_q;
    logic            div_start_s, div_done_s;
    logic [SUMW-1:0] div_dividend_s;
    logic [CNTW-1:0] div_divisor_s;
    logic [QW-1:0]   div_quot_s;

    assign frame_end_s = vsync & ~vsync_q;
    assign href_rise_s = href & ~href_q;
    assign href_fall_s = ~href & href_q;
    // The pixel that coincides with the frame end belongs to neither frame.
    assign match_s = done & ~frame_end_s & ~hue_invalid & (saturation > SAT_MIN)
                   & (value > VAL_MIN) & hue_in_class(colour_sel, hue);
    assign go_s = (count_q >= CNTW'(MIN_PIXELS)) & ~ovf_q;

    // Saturating column/line position counters.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (href_rise_s) begin
            x_d = {XW{1'b0}};
        end else if (done && (x_q != {XW{1'b1}})) begin
            x_d = x_q + XW'(1);
        end else begin
            x_d = x_q;
        end
        if (frame_end_s) begin
            y_d = {YW{1'b0}};
        end else if (href_fall_s && (y_q != {YW{1'b1}})) begin
            y_d = y_q + YW'(1);
        end else begin
            y_d = y_q;
        end
    end

    // Saturating accumulators with sticky overflow, cleared at every frame end.
    always_comb begin
        add_x_s = {1'b0, sum_x_q} + (SUMW+1)'(x_q);
        add_y_s = {1'b0, sum_y_q} + (SUMW+1)'(y_q);
        add_c_s = {1'b0, count_q} + (CNTW+1)'(1);
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (frame_end_s) begin
            sum_x_d = {SUMW{1'b0}};
            sum_y_d = {SUMW{1'b0}};
            count_d = {CNTW{1'b0}};
            ovf_d   = 1'b0;
        end else if (match_s) begin
            sum_x_d = add_x_s[SUMW] ? {SUMW{1'b1}} : add_x_s[SUMW-1:0];
            sum_y_d = add_y_s[SUMW] ? {SUMW{1'b1}} : add_y_s[SUMW-1:0];
            count_d = add_c_s[CNTW] ? {CNTW{1'b1}} : add_c_s[CNTW-1:0];
            ovf_d   = ovf_q | add_x_s[SUMW] | add_y_s[SUMW] | add_c_s[CNTW];
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Edge detectors, position counters and accumulators.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            x_q     <= {XW{1'b0}};
            y_q     <= {YW{1'b0}};
            sum_x_q <= {SUMW{1'b0}};
            sum_y_q <= {SUMW{1'b0}};
            count_q <= {CNTW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
            x_q     <= x_d;
            y_q     <= y_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // X divides straight from the live accumulators; Y uses the snapshot.
    assign div_start_s    = ((state_q == ST_ACCUM) && frame_end_s && go_s)
                          || ((state_q == ST_DIV_X) && div_done_s);
    assign div_dividend_s = (state_q == ST_ACCUM) ? sum_x_q : op_y_q;
    assign div_divisor_s  = (state_q == ST_ACCUM) ? count_q : op_cnt_q;

    blob_centroid_serial_divider #(
        .SUMW (SUMW),
        .CNTW (CNTW),
        .QW   (QW)
    ) u_div (
        .clk        (clk),
        .res_n      (res_n),
        .start_i    (div_start_s),
        .dividend_i (div_dividend_s),
        .divisor_i  (div_divisor_s),
        .done_o     (div_done_s),
        .quotient_o (div_quot_s)
    );

    // Frame-end sequencing and the published result registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q        <= ST_ACCUM;
            op_y_q         <= {SUMW{1'b0}};
            op_cnt_q       <= {CNTW{1'b0}};
            qx_q           <= {XW{1'b0}};
            cx_q           <= {XW{1'b0}};
            cy_q           <= {YW{1'b0}};
            pix_count_q    <= {CNTW{1'b0}};
            found_q        <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    result_valid_q <= 1'b0;
                    if (frame_end_s) begin
                        op_y_q   <= sum_y_q;
                        op_cnt_q <= count_q;
                        if (go_s) begin
                            state_q <= ST_DIV_X;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q        <= ST_PUBLISH;
                            pix_count_q    <= count_q;
                            found_q        <= 1'b0;
                            result_valid_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_ACCUM;
                    end
                end
                ST_DIV_X: begin
                    if (div_done_s) begin
                        qx_q    <= div_quot_s[XW-1:0];
                        state_q <= ST_DIV_Y;
                    end else begin
                        state_q <= ST_DIV_X;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done_s) begin
                        cx_q           <= qx_q;
                        cy_q           <= div_quot_s[YW-1:0];
                        pix_count_q    <= op_cnt_q;
                        found_q        <= 1'b1;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= ST_PUBLISH;
                    end else begin
                        state_q <= ST_DIV_Y;
                    end
                end
                ST_PUBLISH: begin
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    state_q        <= ST_ACCUM;
                end
                default: begin
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    state_q        <= ST_ACCUM;
                end
            endcase
        end
    end

    assign cx           = cx_q;
    assign cy           = cy_q;
    assign pix_count    = pix_count_q;
    assign found        = found_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

endmodule
